// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcodes, register-source decode helpers and
// the hazard sequencer state encoding.
package mips_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned NEED_W = 2;
   localparam int unsigned REM_W  = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

   function automatic logic src_rs(input logic [OP_W-1:0] op);
      return op != OP_J;
   endfunction

   // rt is a true source only for R-type, stores and branches
   function automatic logic src_rt(input logic [OP_W-1:0] op);
      case (op)
         OP_RTYPE, OP_SW, OP_BEQ: return 1'b1;
         OP_LW, OP_ADDI:          return 1'b0;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: number of bubble cycles the ID
// instruction needs before its operands are available (0..2).
module hazard_detect
   import mips_pkg::*;
(
   input  logic [31:0]       instr,
   input  logic              id_ex_mem_read,
   input  logic              id_ex_reg_write,
   input  logic [REG_W-1:0]  id_ex_dest_reg,
   input  logic              ex_mem_mem_read,
   input  logic [REG_W-1:0]  ex_mem_dest_reg,
   output logic [NEED_W-1:0] need
);

   logic [OP_W-1:0]  op;
   logic [REG_W-1:0] rs;
   logic [REG_W-1:0] rt;
   logic             ex_hit;
   logic             mem_hit;
   logic             unused_imm;

   assign op         = instr[31:26];
   assign rs         = instr[25:21];
   assign rt         = instr[20:16];
   assign unused_imm = ^instr[15:0];

   // register 0 is hardwired, so it never creates a dependency
   assign ex_hit  = (id_ex_dest_reg != '0) &&
                    ((src_rs(op) && (id_ex_dest_reg == rs)) ||
                     (src_rt(op) && (id_ex_dest_reg == rt)));
   assign mem_hit = (ex_mem_dest_reg != '0) &&
                    ((src_rs(op) && (ex_mem_dest_reg == rs)) ||
                     (src_rt(op) && (ex_mem_dest_reg == rt)));

   always_comb begin
      need = '0;
      if (op == OP_BEQ) begin
         if (id_ex_mem_read && ex_hit)
            need = NEED_W'(2);
         else if ((id_ex_reg_write && ex_hit) || (ex_mem_mem_read && mem_hit))
            need = NEED_W'(1);
      end else if (id_ex_mem_read && ex_hit) begin
         need = NEED_W'(1);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: ID bubbles, PC/IF-ID holds, IF flushes and
// saturating performance counters for the 5-stage MIPS32 core.
module hazard_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 id_ex_mem_read,
   input  logic                 id_ex_reg_write,
   input  logic [REG_W-1:0]     id_ex_dest_reg,
   input  logic                 ex_mem_mem_read,
   input  logic [REG_W-1:0]     ex_mem_dest_reg,
   input  logic                 branch_taken,
   input  logic                 jump,
   input  logic                 freeze,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_flush,
   output logic                 Data_Hazard,
   output logic                 Control_Hazard,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   seq_state_t        state, state_nxt;
   logic [REM_W-1:0]  rem, rem_nxt;
   logic [NEED_W-1:0] need;
   logic              stall_c;

   hazard_detect u_detect (
      .instr           (instr),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_reg_write (id_ex_reg_write),
      .id_ex_dest_reg  (id_ex_dest_reg),
      .ex_mem_mem_read (ex_mem_mem_read),
      .ex_mem_dest_reg (ex_mem_dest_reg),
      .need            (need)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
      end
   end

   // Outputs follow the current state; reset low forces the idle values
   always_comb begin
      state_nxt      = state;
      rem_nxt        = rem;
      stall_c        = 1'b0;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_flush       = 1'b0;
      Data_Hazard    = 1'b1;
      Control_Hazard = 1'b0;
      if (reset) begin
         if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
         end else begin
            case (state)
               RUN: begin
                  if (need != '0) begin
                     stall_c = 1'b1;
                     if (need == NEED_W'(2)) begin
                        state_nxt = STALL;
                        rem_nxt   = REM_W'(1);
                     end
                  end else if (branch_taken || jump) begin
                     if_flush  = 1'b1;
                     state_nxt = FLUSH;
                  end
               end
               STALL: begin
                  stall_c = 1'b1;
                  rem_nxt = rem - REM_W'(1);
                  if (rem_nxt == '0)
                     state_nxt = RUN;
               end
               FLUSH: begin
                  Control_Hazard = 1'b1;
                  state_nxt      = RUN;
               end
               default: state_nxt = RUN;
            endcase
            if (stall_c) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               Data_Hazard = 1'b0;
            end
         end
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_c && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
         if (if_flush && (flush_count != '1))
            flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares every cycle.
module tb_hazard_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        id_ex_mem_read, id_ex_reg_write;
   logic [4:0]  id_ex_dest_reg;
   logic        ex_mem_mem_read;
   logic [4:0]  ex_mem_dest_reg;
   logic        branch_taken, jump, freeze;
   logic        pc_write, if_id_write, if_flush, Data_Hazard, Control_Hazard;
   logic [15:0] stall_cycles, flush_count;

   // {pc_write, if_id_write, if_flush, Data_Hazard, Control_Hazard}
   localparam logic [4:0] NORM = 5'b11010;
   localparam logic [4:0] STL  = 5'b00000;
   localparam logic [4:0] FLS  = 5'b11110;
   localparam logic [4:0] SQ   = 5'b11011;
   localparam logic [4:0] FRZ  = 5'b00010;

   typedef struct {
      string       name;
      logic [4:0]  ctl;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   hazard_sequencer #(.CNT_WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .instr           (instr),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_reg_write (id_ex_reg_write),
      .id_ex_dest_reg  (id_ex_dest_reg),
      .ex_mem_mem_read (ex_mem_mem_read),
      .ex_mem_dest_reg (ex_mem_dest_reg),
      .branch_taken    (branch_taken),
      .jump            (jump),
      .freeze          (freeze),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_flush        (if_flush),
      .Data_Hazard     (Data_Hazard),
      .Control_Hazard  (Control_Hazard),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
      return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
   endfunction
   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt);
      return {op, rs, rt, 16'h0004};
   endfunction

   // Drive the ID instruction and pipeline-register inputs
   task automatic drive(input logic [31:0] i, input logic mr, rw, input logic [4:0] d,
                        input logic emr, input logic [4:0] ed, input logic bt, jmp);
      instr = i; id_ex_mem_read = mr; id_ex_reg_write = rw; id_ex_dest_reg = d;
      ex_mem_mem_read = emr; ex_mem_dest_reg = ed; branch_taken = bt; jump = jmp;
   endtask

   // Queue the expected outputs for the current cycle, then advance one clock
   task automatic chk(input string nm, input logic [4:0] ctl, input int sc, input int fc);
      exp_t e;
      e.name = nm; e.ctl = ctl; e.sc = 16'(sc); e.fc = 16'(fc);
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [4:0] act;
         e   = sb.pop_front();
         act = {pc_write, if_id_write, if_flush, Data_Hazard, Control_Hazard};
         total++;
         if (act === e.ctl && stall_cycles === e.sc && flush_count === e.fc)
            passed++;
         else
            $display("FAIL %s: got ctl=%b sc=%h fc=%h, expected ctl=%b sc=%h fc=%h",
                     e.name, act, stall_cycles, flush_count, e.ctl, e.sc, e.fc);
      end
   end

   localparam logic [5:0] BEQ = 6'b000100, SW = 6'b101011, ADDI = 6'b001000, JOP = 6'b000010;

   initial begin
      reset = 1'b0; freeze = 1'b0;
      drive(rtype(5'd2, 5'd4, 5'd3), 1, 0, 5'd2, 0, 5'd0, 0, 0);
      @(posedge clk); #1;
      chk("reset_hold", NORM, 0, 0);
      reset = 1'b1; drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle", NORM, 0, 0);
      // load-use on add
      drive(rtype(5'd2, 5'd4, 5'd3), 1, 0, 5'd2, 0, 5'd0, 0, 0); chk("lu_stall", STL, 0, 0);
      drive(rtype(5'd2, 5'd4, 5'd3), 0, 0, 5'd0, 0, 5'd0, 0, 0); chk("lu_bubble", NORM, 1, 0);
      // load feeding beq: two bubbles, taken branch ignored meanwhile
      drive(itype(BEQ, 5'd5, 5'd0), 1, 0, 5'd5, 0, 5'd0, 1, 0); chk("beq_ld_run", STL, 1, 0);
      drive(itype(BEQ, 5'd5, 5'd0), 0, 0, 5'd0, 0, 5'd0, 1, 0); chk("beq_ld_stall", STL, 2, 0);
      chk("beq_eval", FLS, 3, 0);
      drive(itype(BEQ, 5'd5, 5'd0), 1, 0, 5'd5, 0, 5'd0, 1, 0); chk("flush_squash", SQ, 3, 1);
      drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("after_flush", NORM, 3, 1);
      // plain taken branch and jump
      drive(itype(BEQ, 5'd1, 5'd2), 0, 0, 0, 0, 0, 1, 0); chk("beq_taken", FLS, 3, 1);
      drive(32'h0, 0, 0, 0, 0, 0, 0, 1); chk("squash_jump", SQ, 3, 2);
      drive({JOP, 5'd7, 21'd0}, 1, 0, 5'd7, 0, 0, 0, 1); chk("j_noread", FLS, 3, 2);
      drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("j_squash", SQ, 3, 3);
      // source decode boundaries
      drive(rtype(5'd0, 5'd0, 5'd1), 1, 0, 5'd0, 0, 0, 0, 0); chk("r0_nostall", NORM, 3, 3);
      drive(itype(ADDI, 5'd1, 5'd5), 1, 0, 5'd5, 0, 0, 0, 0); chk("addi_rt", NORM, 3, 3);
      drive(itype(SW, 5'd1, 5'd6), 1, 0, 5'd6, 0, 0, 0, 0); chk("sw_rt", STL, 3, 3);
      drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("sw_bubble", NORM, 4, 3);
      drive(itype(BEQ, 5'd8, 5'd9), 0, 1, 5'd9, 0, 0, 0, 0); chk("beq_ex_alu", STL, 4, 3);
      drive(itype(BEQ, 5'd8, 5'd9), 0, 0, 0, 0, 0, 0, 0); chk("beq_ex_alu_clr", NORM, 5, 3);
      drive(itype(BEQ, 5'd8, 5'd9), 0, 0, 0, 1, 5'd8, 0, 0); chk("beq_mem_ld", STL, 5, 3);
      drive(itype(BEQ, 5'd8, 5'd9), 0, 0, 0, 0, 0, 0, 0); chk("beq_mem_ld_clr", NORM, 6, 3);
      drive(rtype(5'd2, 5'd4, 5'd3), 0, 0, 0, 1, 5'd2, 0, 0); chk("add_mem_ld", NORM, 6, 3);
      // freeze in the middle of a two-cycle stall
      drive(itype(BEQ, 5'd5, 5'd0), 1, 0, 5'd5, 0, 0, 1, 0); chk("frz_run", STL, 6, 3);
      freeze = 1'b1;
      for (int k = 0; k < 3; k++) chk("frz_hold", FRZ, 7, 3);
      freeze = 1'b0; drive(itype(BEQ, 5'd5, 5'd0), 0, 0, 0, 0, 0, 0, 0);
      chk("frz_release", STL, 7, 3);
      drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("frz_done", NORM, 8, 3);
      drive(itype(BEQ, 5'd1, 5'd2), 0, 0, 0, 0, 0, 1, 0); freeze = 1'b1;
      chk("frz_branch", FRZ, 8, 3);
      freeze = 1'b0; drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("frz_branch_rel", NORM, 8, 3);
      // asynchronous reset mid-stall
      drive(itype(BEQ, 5'd5, 5'd0), 1, 0, 5'd5, 0, 0, 1, 0); chk("rst_run", STL, 8, 3);
      reset = 1'b0; chk("rst_async", NORM, 0, 0);
      reset = 1'b1; drive(32'h0, 0, 0, 0, 0, 0, 0, 0); chk("rst_release", NORM, 0, 0);
      // long load-use stall saturates the stall counter
      drive(rtype(5'd2, 5'd4, 5'd3), 1, 0, 5'd2, 0, 0, 0, 0);
      for (int k = 0; k < 65540; k++) @(posedge clk);
      #1;
      chk("sat_a", STL, 16'hFFFF, 0);
      chk("sat_b", STL, 16'hFFFF, 0);
      repeat (2) @(posedge clk);
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
